// File: rtl/mem_fetch_sequencer.sv
// Fetch arbiter and four-phase PH0 sequencer for the dual-rail memory-data demux.
// Optional per-state watchdog with sticky err: define MEM_FETCH_SEQ_TIMEOUT_EN.
module mem_fetch_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_I_BURST = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic mem_rdy,
  input  logic comp_data,
  input  logic comp_null,
  output logic PH0_t,
  output logic PH0_f,
  output logic mem_en,
  output logic i_gnt,
  output logic d_gnt,
  output logic i_done,
  output logic d_done,
  output logic busy,
  output logic err
);

  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_DATA, S_NULL_WAIT} state_t;

  localparam logic [3:0] MAX_BURST = 4'(MAX_I_BURST);

  if (SYNC_STAGES < 2 || MAX_I_BURST < 1 || MAX_I_BURST > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mem_fetch_sequencer: parameter out of range");
  end

  state_t                 r_state, w_state_next;
  logic [3:0]             r_burst_cnt, w_burst_next;
  logic [SYNC_STAGES-1:0] r_data_sync, r_null_sync;
  logic r_ph0_t, r_ph0_f, r_mem_en, r_i_gnt, r_d_gnt, r_i_done, r_d_done, r_busy;
  logic w_ph0_t_next, w_ph0_f_next, w_mem_en_next, w_i_gnt_next, w_d_gnt_next;
  logic w_i_done_next, w_d_done_next;
  logic w_data_synced, w_null_synced, w_d_wins, w_abort;

`ifdef MEM_FETCH_SEQ_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err, r_abort, w_err_next, w_abort_next, w_timeout;

  assign w_timeout = (r_state != S_IDLE) && (r_tmo_cnt == TMO_LAST);
  assign w_abort   = r_abort;
  assign err       = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  assign w_data_synced = r_data_sync[SYNC_STAGES-1];
  assign w_null_synced = r_null_sync[SYNC_STAGES-1];
  // Constant path wins once the instruction side has used up its burst allowance.
  assign w_d_wins      = d_req && (!i_req || (r_burst_cnt == MAX_BURST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_sync <= '0;
      r_null_sync <= '0;
    end else begin
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], comp_data};
      r_null_sync <= {r_null_sync[SYNC_STAGES-2:0], comp_null};
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_burst_next  = r_burst_cnt;
    w_ph0_t_next  = r_ph0_t;
    w_ph0_f_next  = r_ph0_f;
    w_mem_en_next = r_mem_en;
    w_i_gnt_next  = r_i_gnt;
    w_d_gnt_next  = r_d_gnt;
    w_i_done_next = 1'b0;
    w_d_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A done pulse in flight blocks arbitration so a held req is not regranted.
        if ((i_req || d_req) && !r_i_done && !r_d_done) begin
          w_state_next  = S_MEM_WAIT;
          w_mem_en_next = 1'b1;
          if (w_d_wins) begin
            w_d_gnt_next = 1'b1;
            w_burst_next = '0;
          end else begin
            w_i_gnt_next = 1'b1;
            if (r_burst_cnt != MAX_BURST) w_burst_next = r_burst_cnt + 4'd1;
          end
        end
      end
      S_MEM_WAIT: begin
        if (mem_rdy) begin
          w_state_next  = S_DATA;
          w_mem_en_next = 1'b0;
          w_ph0_t_next  = r_i_gnt;
          w_ph0_f_next  = r_d_gnt;
        end
      end
      S_DATA: begin
        if (w_data_synced) begin
          w_state_next = S_NULL_WAIT;
          w_ph0_t_next = 1'b0;
          w_ph0_f_next = 1'b0;
        end
      end
      S_NULL_WAIT: begin
        if (w_null_synced) begin
          w_state_next  = S_IDLE;
          w_i_gnt_next  = 1'b0;
          w_d_gnt_next  = 1'b0;
          w_i_done_next = r_i_gnt & ~w_abort;
          w_d_done_next = r_d_gnt & ~w_abort;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
`ifdef MEM_FETCH_SEQ_TIMEOUT_EN
    w_err_next   = r_err;
    w_abort_next = r_abort;
    if (w_timeout && (w_state_next == r_state)) begin
      w_err_next = 1'b1;
      if (r_state == S_NULL_WAIT) begin
        w_state_next = S_IDLE;
        w_i_gnt_next = 1'b0;
        w_d_gnt_next = 1'b0;
      end else begin
        w_state_next  = S_NULL_WAIT;
        w_abort_next  = 1'b1;
        w_ph0_t_next  = 1'b0;
        w_ph0_f_next  = 1'b0;
        w_mem_en_next = 1'b0;
      end
    end
    if (w_state_next == S_IDLE) w_abort_next = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_ph0_t     <= 1'b0;
      r_ph0_f     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_i_gnt     <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_burst_cnt <= w_burst_next;
      r_ph0_t     <= w_ph0_t_next;
      r_ph0_f     <= w_ph0_f_next;
      r_mem_en    <= w_mem_en_next;
      r_i_gnt     <= w_i_gnt_next;
      r_d_gnt     <= w_d_gnt_next;
      r_i_done    <= w_i_done_next;
      r_d_done    <= w_d_done_next;
      r_busy      <= (w_state_next != S_IDLE);
    end
  end

`ifdef MEM_FETCH_SEQ_TIMEOUT_EN
  // Counter restarts on every state change and parks at its limit while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_err   <= w_err_next;
      r_abort <= w_abort_next;
      if (w_state_next != r_state)  r_tmo_cnt <= '0;
      else if (r_tmo_cnt != TMO_LAST) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`endif

  assign PH0_t  = r_ph0_t;
  assign PH0_f  = r_ph0_f;
  assign mem_en = r_mem_en;
  assign i_gnt  = r_i_gnt;
  assign d_gnt  = r_d_gnt;
  assign i_done = r_i_done;
  assign d_done = r_d_done;
  assign busy   = r_busy;

endmodule

// File: tb/tb_mem_fetch_sequencer.sv
// Bench for mem_fetch_sequencer: directed cycle-exact fetch, then randomized transactions
// checked against a grant-history arbitration model and the fixed handshake latencies.
module tb_mem_fetch_sequencer;
  localparam int SYNC = 2;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, mem_rdy = 1'b0, comp_data = 1'b0, comp_null = 1'b0;
  logic PH0_t, PH0_f, mem_en, i_gnt, d_gnt, i_done, d_done, busy, err;

  int compared = 0;
  int mismatched = 0;
  bit hist[$];  // grant history, 1 = instruction grant

  always #5 clk = ~clk;

  mem_fetch_sequencer #(.SYNC_STAGES(SYNC), .MAX_I_BURST(MAXB), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .d_req(d_req), .mem_rdy(mem_rdy),
    .comp_data(comp_data), .comp_null(comp_null), .PH0_t(PH0_t), .PH0_f(PH0_f),
    .mem_en(mem_en), .i_gnt(i_gnt), .d_gnt(d_gnt), .i_done(i_done), .d_done(d_done),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Instruction side may take MAXB consecutive grants while the constant side waits.
  function automatic bit predict_i(input bit ir, input bit dr);
    int trail = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (!hist[k]) break;
      trail++;
    end
    return !(dr && (!ir || trail >= MAXB));
  endfunction

  always @(negedge clk) begin
    compared++;
    assert (!(PH0_t && PH0_f)) else begin
      mismatched++;
      $error("FAIL rails_exclusive: observed t=%0b f=%0b expected not both 1", PH0_t, PH0_f);
    end
  end

  task automatic run_txn(input bit ir, input bit dr, input bit spur);
    bit exp_i;
    int n, mem_dly, data_dly, null_dly;
    exp_i = predict_i(ir, dr);
    hist.push_back(exp_i);
    mem_dly  = spur ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 3));
    data_dly = $urandom_range(0, 2);
    null_dly = $urandom_range(0, 2);
    i_req = ir;
    d_req = dr;
    tick();
    check("gnt_i", i_gnt, exp_i);
    check("gnt_d", d_gnt, !exp_i);
    check("mem_en_on", mem_en, 1);
    check("busy_on", busy, 1);
    if ($urandom_range(0, 1) == 1) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    if (spur) comp_data = 1'b1;
    for (int k = 0; k < mem_dly; k++) begin
      tick();
      comp_data = 1'b0;
      check("mem_en_hold", mem_en, 1);
    end
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    check("rail_t", PH0_t, exp_i);
    check("rail_f", PH0_f, !exp_i);
    check("mem_en_off", mem_en, 0);
    if (spur) begin
      comp_null = 1'b1;
      tick();
      comp_null = 1'b0;
    end
    repeat (data_dly) tick();
    comp_data = 1'b1;
    tick();
    n = 1;
    while ((PH0_t || PH0_f) && n < 20) begin
      tick();
      n++;
    end
    check("data_lat", n, SYNC + 1);
    comp_data = 1'b0;
    check("gnt_stable", exp_i ? i_gnt : d_gnt, 1);
    repeat (null_dly) tick();
    comp_null = 1'b1;
    tick();
    n = 1;
    while (!(i_done || d_done) && n < 20) begin
      tick();
      n++;
    end
    check("null_lat", n, SYNC + 1);
    check("done_i", i_done, exp_i);
    check("done_d", d_done, !exp_i);
    check("gnt_clr", i_gnt | d_gnt, 0);
    check("busy_off", busy, 0);
    comp_null = 1'b0;
    tick();
    check("done_pulse", i_done | d_done, 0);
    check("no_rearb", busy, 0);
    $display("txn req=%0b%0b spur=%0b grant=%s", ir, dr, spur, exp_i ? "I" : "D");
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("reset_outs", {PH0_t, PH0_f, mem_en, i_gnt, d_gnt, i_done, d_done, busy, err}, 0);
    rst_n = 1'b1;
    tick();

    // Cycle-exact instruction fetch (cycle 0 = this point).
    i_req = 1'b1;
    hist.push_back(predict_i(1'b1, 1'b0));
    tick();
    check("c1_i_gnt", i_gnt, 1);
    check("c1_d_gnt", d_gnt, 0);
    check("c1_mem_en", mem_en, 1);
    check("c1_ph0_t", PH0_t, 0);
    repeat (2) tick();
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    check("c4_ph0_t", PH0_t, 1);
    check("c4_ph0_f", PH0_f, 0);
    check("c4_mem_en", mem_en, 0);
    tick();
    comp_data = 1'b1;
    repeat (2) tick();
    check("c7_ph0_t", PH0_t, 1);
    tick();
    check("c8_ph0_t", PH0_t, 0);
    comp_data = 1'b0;
    repeat (2) tick();
    comp_null = 1'b1;
    repeat (2) tick();
    check("c12_i_done", i_done, 0);
    tick();
    check("c13_i_done", i_done, 1);
    check("c13_i_gnt", i_gnt, 0);
    check("c13_ph0_f", PH0_f, 0);
    i_req = 1'b0;
    comp_null = 1'b0;
    tick();
    check("c14_i_done", i_done, 0);
    check("c14_busy", busy, 0);
    $display("txn directed instruction fetch done");

    // Spurious completion and mem_rdy in IDLE, then a constant fetch.
    comp_data = 1'b1;
    mem_rdy = 1'b1;
    tick();
    comp_data = 1'b0;
    mem_rdy = 1'b0;
    check("idle_spur_busy", busy, 0);
    run_txn(1'b0, 1'b1, 1'b1);

    // Burst fairness with both requesters held.
    for (int k = 0; k < 10; k++) run_txn(1'b1, 1'b1, 1'b0);

    // Randomized mix.
    for (int k = 0; k < 16; k++) begin
      bit ir, dr;
      ir = 1'($urandom_range(0, 1));
      dr = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(ir, dr, 1'($urandom_range(0, 1)));
    end

    // Saturate the burst, then reset mid-DATA.
    for (int k = 0; k < 4; k++) run_txn(1'b1, 1'b0, 1'b0);
    i_req = 1'b1;
    tick();
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    check("pre_rst_ph0_t", PH0_t, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ph0_t", PH0_t, 0);
    check("rst_gnt", i_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    $display("txn reset asserted mid-DATA");
    hist.delete();
    i_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(1'b1, 1'b1, 1'b0);
    check("err_clear", err, 0);

`ifdef MEM_FETCH_SEQ_TIMEOUT_EN
    i_req = 1'b1;
    tick();
    check("tmo_gnt", i_gnt, 1);
    i_req = 1'b0;
    repeat (15) tick();
    check("tmo_err_early", err, 0);
    check("tmo_mem_en_early", mem_en, 1);
    tick();
    check("tmo_err", err, 1);
    check("tmo_mem_en", mem_en, 0);
    check("tmo_rails", {PH0_t, PH0_f}, 0);
    comp_null = 1'b1;
    tick();
    n = 1;
    while (busy && n < 20) begin
      check("tmo_no_done", i_done | d_done, 0);
      tick();
      n++;
    end
    comp_null = 1'b0;
    check("tmo_null_lat", n, SYNC + 1);
    check("tmo_idle_done", i_done | d_done, 0);
    check("tmo_err_sticky", err, 1);
    $display("txn watchdog abort");
`else
    n = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_fetch_sequencer.md
Name: mem_fetch_sequencer

Overview:
- Clocked controller that sequences the dual-rail memory-data demux.
- Arbitrates between the instruction-fetch and operand/constant-fetch requesters, enables the memory read, and drives dual-rail PH0 (PH0_t selects the instruction path I*, PH0_f selects the constant path C*).
- Runs the four-phase NCL cycle DATA -> completion -> NULL -> completion before the next grant.
- Sits between the fetch/execute control logic and the demux plus its completion detector.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each completion input (minimum 2).
- MAX_I_BURST, 4: consecutive instruction grants allowed while d_req is pending (range 1..15).
- TIMEOUT, 64: watchdog limit in cycles per state; used only with the optional feature.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  instruction-fetch request; level, held until i_done.
- d_req  in  1  operand/constant fetch request; level, held until d_done.
- mem_rdy  in  1  memory read data valid on dual-rail D7..D0.
- comp_data  in  1  raw completion detector: all demux outputs DATA. Asynchronous; synchronized internally.
- comp_null  in  1  raw completion detector: all demux outputs NULL. Asynchronous; synchronized internally.
- PH0_t  out  1  phase rail true: route to I path.
- PH0_f  out  1  phase rail false: route to C path.
- mem_en  out  1  memory read enable.
- i_gnt  out  1  instruction requester owns the transaction.
- d_gnt  out  1  constant requester owns the transaction.
- i_done  out  1  one-cycle pulse: instruction transfer complete.
- d_done  out  1  one-cycle pulse: constant transfer complete.
- busy  out  1  state != IDLE.
- err  out  1  sticky watchdog error; constant 0 without the optional feature.

Behaviour:
- Reset: all outputs 0, state IDLE, burst_cnt 0, synchronizers cleared. Asserting rst_n low mid-transaction drops PH0 rails to 00 immediately (asynchronously).
- All outputs are registered. PH0_t and PH0_f are never 1 together.
- States: IDLE, MEM_WAIT, DATA, NULL_WAIT.
- IDLE:
  - If i_req or d_req is sampled high, arbitrate. The next cycle enters MEM_WAIT with the selected gnt=1 and mem_en=1.
  - Arbitration: d wins if i_req=0 or burst_cnt==MAX_I_BURST; otherwise i wins.
  - An i grant increments burst_cnt (saturating at MAX_I_BURST). A d grant clears burst_cnt.
  - mem_rdy, comp_data and comp_null are ignored in IDLE.
- MEM_WAIT: on mem_rdy=1, the next cycle enters DATA with mem_en=0 and the rail asserted (PH0_t for i, PH0_f for d).
- DATA: hold the rail. On synced comp_data=1, the next cycle enters NULL_WAIT with rails 00. comp_null is ignored in DATA.
- NULL_WAIT:
  - On synced comp_null=1, the next cycle enters IDLE, clears gnt, and pulses the matching done for exactly 1 cycle.
  - comp_data is ignored in NULL_WAIT.
- Grant stability: gnt is constant from MEM_WAIT through NULL_WAIT.
- Dropping a req mid-transaction is ignored; the transfer completes and done still pulses.
- Back-to-back: a req still high in the cycle done pulses is not re-arbitrated before the following cycle. The requester must drop req on done.
- Minimum transaction: 1 (grant) + 1 (mem_rdy) + SYNC_STAGES+1 (DATA) + SYNC_STAGES+1 (NULL) cycles.

Optional Feature:
- Macro: MEM_FETCH_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter resets on every state entry.
  - When the counter reaches TIMEOUT in MEM_WAIT or DATA: set err, go to NULL_WAIT, rails 00, mem_en 0.
  - When the counter reaches TIMEOUT in NULL_WAIT: set err, go to IDLE, clear gnt, no done pulse.
  - err stays set until rst_n.
- Undefined: no counter logic; err tied to 0; states wait indefinitely.

Test Plan:
- Instruction fetch: i_req=1 at cycle 0, mem_rdy at cycle 3, comp_data raw at cycle 5, comp_null raw 2 cycles after PH0_t falls -> i_gnt/mem_en high at cycle 1, PH0_t=1 at cycle 4 and falls at cycle 8 (SYNC_STAGES=2), i_done single pulse, PH0_f stays 0 throughout.
- Constant fetch: d_req only -> PH0_f rail used, d_done pulses, burst_cnt reads 0 afterwards.
- Burst fairness: i_req and d_req held continuously, MAX_I_BURST=4 -> grant order i,i,i,i,d,i,i,i,i,d.
- Reset mid-DATA: rst_n low while PH0_t=1 -> PH0_t, gnt and busy are 0 without a clock edge. After release, IDLE with a fresh arbitration and burst_cnt 0.
- Spurious completions: comp_data pulsed in IDLE and MEM_WAIT, comp_null pulsed in DATA -> no state change, no done pulse.
- With MEM_FETCH_SEQ_TIMEOUT_EN, TIMEOUT=16, mem_rdy never asserted -> after 16 cycles in MEM_WAIT: err=1, rails 00. With comp_null=1 -> IDLE, no done pulse, err remains 1.
